// File: rtl/bit3_comparator.sv
// bit3_comparator: registered magnitude comparator with one-hot gt/eq/lt result.
// Operands are sampled on in_valid; the result holds until the next sample.
// chg pulses for one cycle when a new result class differs from the held one.
// Optional macro BIT3_CMP_SIGNED_EN: when defined, operands compare as
// two's-complement signed values; otherwise they compare as unsigned.
module bit3_comparator #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             out_valid,
    output logic             chg
);

    // Flipping the sign bit maps two's-complement ordering onto unsigned
    // ordering, so one unsigned compare chain serves both modes.
`ifdef BIT3_CMP_SIGNED_EN
    localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};
`else
    localparam logic [WIDTH-1:0] SIGN_FLIP = '0;
`endif

    logic [WIDTH-1:0] a_ord;
    logic [WIDTH-1:0] b_ord;
    logic [WIDTH:0]   gt_chain;
    logic [WIDTH:0]   lt_chain;

    logic gt_cmp, eq_cmp, lt_cmp;

    logic gt_reg, eq_reg, lt_reg, out_valid_reg, chg_reg;
    logic gt_next, eq_next, lt_next, out_valid_next, chg_next;

    assign a_ord = a ^ SIGN_FLIP;
    assign b_ord = b ^ SIGN_FLIP;

    // Ripple from LSB to MSB: a higher bit that differs overrides any
    // decision made by the lower bits; equal bits pass the lower decision up.
    assign gt_chain[0] = 1'b0;
    assign lt_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cmp_bit
            logic bit_same;
            assign bit_same         = ~(a_ord[gi] ^ b_ord[gi]);
            assign gt_chain[gi + 1] = (a_ord[gi] & ~b_ord[gi]) | (bit_same & gt_chain[gi]);
            assign lt_chain[gi + 1] = (~a_ord[gi] & b_ord[gi]) | (bit_same & lt_chain[gi]);
        end
    endgenerate

    // Equality is simply "neither greater nor less", which keeps the
    // three flags one-hot by construction.
    assign gt_cmp = gt_chain[WIDTH];
    assign lt_cmp = lt_chain[WIDTH];
    assign eq_cmp = ~gt_cmp & ~lt_cmp;

    // Next-state: capture a new result on in_valid, otherwise hold. The
    // pre-valid all-zero state never equals a one-hot result, so the first
    // sample after reset naturally raises chg.
    always_comb begin
        gt_next        = gt_reg;
        eq_next        = eq_reg;
        lt_next        = lt_reg;
        out_valid_next = out_valid_reg;
        chg_next       = 1'b0;
        if (in_valid) begin
            gt_next        = gt_cmp;
            eq_next        = eq_cmp;
            lt_next        = lt_cmp;
            out_valid_next = 1'b1;
            chg_next       = ({gt_cmp, eq_cmp, lt_cmp} != {gt_reg, eq_reg, lt_reg});
        end
    end

    // Result and status registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_reg        <= 1'b0;
            eq_reg        <= 1'b0;
            lt_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            chg_reg       <= 1'b0;
        end else begin
            gt_reg        <= gt_next;
            eq_reg        <= eq_next;
            lt_reg        <= lt_next;
            out_valid_reg <= out_valid_next;
            chg_reg       <= chg_next;
        end
    end

    assign gt        = gt_reg;
    assign eq        = eq_reg;
    assign lt        = lt_reg;
    assign out_valid = out_valid_reg;
    assign chg       = chg_reg;

endmodule

// File: tb/tb_bit3_comparator.sv
// Testbench for bit3_comparator: stimulus pushes expected results into a
// queue each cycle; a monitor on the falling edge pops and compares.
module tb_bit3_comparator;

    localparam int WIDTH = 3;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             gt, eq, lt, out_valid, chg;

    typedef struct {
        logic [2:0] cls;   // {gt,eq,lt}
        logic       ov;
        logic       chg;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    int         n_total;
    int         n_pass;
    logic [2:0] prev_cls;

    bit3_comparator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt),
        .out_valid (out_valid),
        .chg       (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference compare used for the exhaustive and hold phases.
    function automatic logic [2:0] ref_cls(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef BIT3_CMP_SIGNED_EN
        if ($signed(x) > $signed(y)) return 3'b100;
        if ($signed(x) < $signed(y)) return 3'b001;
`else
        if (x > y) return 3'b100;
        if (x < y) return 3'b001;
`endif
        return 3'b010;
    endfunction

    // Apply one cycle of stimulus and queue the response expected after it.
    task automatic drive(input logic v, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                         input logic [2:0] ecls, input logic eov, input logic echg, input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        in_valid = v;
        a        = xa;
        b        = xb;
        @(posedge clk);
        e.cls  = ecls;
        e.ov   = eov;
        e.chg  = echg;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Directed sample with a hand-computed class; chg is derived from the
    // previously expected class.
    task automatic sample(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic [2:0] ecls, input logic echg, input string nm);
        drive(1'b1, xa, xb, ecls, 1'b1, echg, nm);
        prev_cls = ecls;
    endtask

    // Monitor: one expected entry per clock, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_total++;
            if ({gt, eq, lt} === e.cls && out_valid === e.ov && chg === e.chg) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got gel=%b ov=%b chg=%b, want gel=%b ov=%b chg=%b",
                         e.name, {gt, eq, lt}, out_valid, chg, e.cls, e.ov, e.chg);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] c;
        n_total  = 0;
        n_pass   = 0;
        prev_cls = 3'b000;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: everything stays zero.
        for (int i = 0; i < 4; i++) drive(1'b0, 3'(i), 3'(7 - i), 3'b000, 1'b0, 1'b0, "idle_after_reset");

`ifndef BIT3_CMP_SIGNED_EN
        sample(3'b111, 3'b000, 3'b100, 1'b1, "u_7_gt_0");
        sample(3'b000, 3'b111, 3'b001, 1'b1, "u_0_lt_7");
        sample(3'b111, 3'b111, 3'b010, 1'b1, "u_7_eq_7");
        sample(3'b100, 3'b000, 3'b100, 1'b1, "u_4_gt_0");
        sample(3'b110, 3'b100, 3'b100, 1'b0, "u_6_gt_4_same");
        sample(3'b011, 3'b111, 3'b001, 1'b1, "u_3_lt_7");
        sample(3'b000, 3'b001, 3'b001, 1'b0, "u_0_lt_1_same");
`else
        sample(3'b111, 3'b000, 3'b001, 1'b1, "s_m1_lt_0");
        sample(3'b011, 3'b100, 3'b100, 1'b1, "s_3_gt_m4");
        sample(3'b101, 3'b101, 3'b010, 1'b1, "s_m3_eq_m3");
`endif

        // Hold: a/b wander while in_valid is low, result must not move.
        c = ref_cls(3'b101, 3'b010);
        sample(3'b101, 3'b010, c, (c != prev_cls), "hold_sample");
        for (int i = 0; i < 5; i++)
            drive(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), c, 1'b1, 1'b0, "hold_idle");

        // Async reset between edges clears outputs without a clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({gt, eq, lt, out_valid, chg} === 5'b00000) n_pass++;
        else $display("FAIL async_reset: got gel=%b ov=%b chg=%b, want 000/0/0",
                      {gt, eq, lt}, out_valid, chg);
        @(negedge clk);
        #1;
        rst_n    = 1'b1;
        prev_cls = 3'b000;
        drive(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, "idle_after_async_reset");
        c = ref_cls(3'b010, 3'b010);
        sample(3'b010, 3'b010, c, 1'b1, "first_after_async_reset");

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 64; i++) begin
            logic [2:0] xa, xb;
            xa = 3'(i >> 3);
            xb = 3'(i & 7);
            c  = ref_cls(xa, xb);
            sample(xa, xb, c, (c != prev_cls), $sformatf("exh_a%0d_b%0d", xa, xb));
        end
        drive(1'b0, 3'b000, 3'b000, prev_cls, 1'b1, 1'b0, "tail_idle");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
